pipe_elastic_reg: RTL and testbench
===================================

Name: pipe_elastic_reg

Overview:
Parametrised successor to the single-stage enabled DFF: an elastic pipeline register of DEPTH entries, each SIZE bits wide, with a valid/ready handshake on both sides.
- Used between datapath stages so a downstream stall back-pressures the upstream stage instead of relying on a global write_enable.
- Adds a synchronous flush for branch/exception squash and an occupancy count.

Parameters:
SIZE, 32, data width in bits (>=1)
DEPTH, 2, number of storage entries (>=1; need not be a power of two)
CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; do not override)
STAT_W, 16, stall-counter width (used only with PIPE_STATS_EN)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
flush  input  1  synchronous squash of all held entries
in_valid  input  1  upstream has data
in_data  input  SIZE  upstream data
in_ready  output  1  block can accept this cycle
out_valid  output  1  head entry valid
out_data  output  SIZE  head entry data
out_ready  input  1  downstream accepts this cycle
count  output  CNT_W  entries currently held
stall_cycles  output  STAT_W  saturating stall counter (present only with PIPE_STATS_EN)

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous release): count=0, read/write pointers=0, storage cleared to 0, stall_cycles=0. Consequently out_valid=0, out_data=0, in_ready=1.
- Push: occurs when in_valid && in_ready at the clk edge. Data is written at the write pointer, and the pointer advances, wrapping from DEPTH-1 to 0.
- Pop: occurs when out_valid && out_ready at the clk edge. The read pointer advances with the same wrap rule.
- in_ready = (count < DEPTH). It is derived from registered state only and has no combinational path from out_ready. When full, no push is accepted even if a pop happens in the same cycle.
- out_valid = (count != 0).
- out_data = entry at the read pointer when out_valid=1, else forced to 0.
- Latency: data pushed at edge N is visible on out_data after edge N. The minimum in-to-out latency is one cycle; there is no combinational data bypass.
- Simultaneous push and pop (0 < count < DEPTH): count is unchanged and both pointers advance.
- Push only: count+1. Pop only: count-1.
- Order: strict FIFO. Data is never reordered, duplicated or dropped except by flush.
- Flush has highest priority after reset. On the edge where flush=1:
  - count=0 and both pointers=0;
  - any same-cycle push or pop is discarded;
  - storage contents are left as-is but are invisible, because out_data is forced to 0.
- in_ready is 1 in the cycle after a flush.
- With DEPTH=1, the block behaves as a half-throughput register stage: it alternates accept and drain under continuous traffic.
- With DEPTH=2, full throughput is sustained with registered in_ready.
- Reset asserted mid-transfer: all state clears immediately and asynchronously. Held data is lost.
- Protocol assumption on upstream: in_data is stable while in_valid=1 and in_ready=0. The block does not check this.

Optional Feature:
PIPE_STATS_EN
- Defined: adds output stall_cycles.
  - Increments by 1 on each clk edge where in_valid=1 and in_ready=0.
  - Saturates at 2^STAT_W-1.
  - Cleared only by reset; flush does not affect it.
- Undefined: the stall_cycles port and counter are absent. All other behaviour is identical.

Test Plan:
1. Reset → values: hold reset=0 → out_valid=0, out_data=0, in_ready=1, count=0. Release, then push 0xA5A5_0001 → next cycle out_valid=1, out_data=0xA5A5_0001, count=1.
2. Fill and back-pressure (DEPTH=2): out_ready=0; push 0x11, 0x22, then offer 0x33 → count=2, in_ready=0, 0x33 not accepted. Set out_ready=1 → outputs 0x11, 0x22, 0x33 in order.
3. Streaming: DEPTH=2, in_valid=out_ready=1 for 100 cycles with incrementing data 0..99 → 1 transfer per cycle after the first, count stays 1, sequence intact.
4. Flush: count=2 holding 0x44, 0x55; flush=1 together with in_valid=1, in_data=0x66 → next cycle count=0, out_valid=0, out_data=0; 0x66 never appears.
5. Wrap and odd depth: DEPTH=3, push/pop 10 values with random out_ready gaps → order preserved across pointer wrap, count never exceeds 3.
6. Stats (PIPE_STATS_EN, STAT_W=4): hold full with in_valid=1 for 20 cycles → stall_cycles saturates at 15. Flush → stays 15. Reset → 0.

Source files
------------

// File: rtl/pipe_elastic_reg_if.sv
// Valid/ready bundle for pipe_elastic_reg: upstream (in_*) and downstream (out_*) sides.
// master = traffic source/sink around the block, slave = the register itself.
interface pipe_elastic_reg_if #(
    parameter int SIZE = 32
);
    logic            in_valid;
    logic [SIZE-1:0] in_data;
    logic            in_ready;
    logic            out_valid;
    logic [SIZE-1:0] out_data;
    logic            out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_elastic_reg.sv
// Elastic DEPTH-entry pipeline register with flush and occupancy count; PIPE_STATS_EN adds stall_cycles.
// Latency: one cycle in-to-out, no combinational data bypass.
// Backpressure: in_ready = count < DEPTH from registered state only; a full block refuses pushes even on a pop.
module pipe_elastic_reg #(
    parameter int SIZE  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
`ifdef PIPE_STATS_EN
    ,
    parameter int STAT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    pipe_elastic_reg_if.slave bus,
    output logic [CNT_W-1:0] count
`ifdef PIPE_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_cycles
`endif
);

    localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    logic [SIZE-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic w_in_ready;
    logic w_out_valid;
    logic w_push;
    logic w_pop;

    assign w_in_ready  = (r_count < FULL);
    assign w_out_valid = (r_count != '0);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= ptr_next(r_wptr);
            if (w_pop)  r_rptr <= ptr_next(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Flush leaves storage untouched; out_data masking hides stale entries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (!flush && w_push) begin
            r_mem[r_wptr] <= bus.in_data;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_valid ? r_mem[r_rptr] : '0;
    assign count         = r_count;

`ifdef PIPE_STATS_EN
    logic [STAT_W-1:0] r_stall;

    // Counts refused offers; survives flush, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall <= '0;
        end else if (bus.in_valid && !w_in_ready && (r_stall != '1)) begin
            r_stall <= r_stall + STAT_W'(1);
        end
    end

    assign stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// Bench for pipe_elastic_reg: DEPTH=2 and DEPTH=3 instances share stimulus, each checked against a queue model.
module tb_pipe_elastic_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        flush;
    logic        drv_v;
    logic [31:0] drv_d;
    logic        drv_r;

    pipe_elastic_reg_if #(.SIZE(32)) b2 ();
    pipe_elastic_reg_if #(.SIZE(32)) b3 ();

    assign b2.in_valid  = drv_v;
    assign b2.in_data   = drv_d;
    assign b2.out_ready = drv_r;
    assign b3.in_valid  = drv_v;
    assign b3.in_data   = drv_d;
    assign b3.out_ready = drv_r;

    logic [1:0] cnt2;
    logic [1:0] cnt3;
`ifdef PIPE_STATS_EN
    logic [3:0] st2;
    logic [3:0] st3;
`endif

    pipe_elastic_reg #(
        .SIZE(32), .DEPTH(2)
`ifdef PIPE_STATS_EN
        , .STAT_W(4)
`endif
    ) u2 (
        .clk(clk), .reset(rst_n), .flush(flush), .bus(b2), .count(cnt2)
`ifdef PIPE_STATS_EN
        , .stall_cycles(st2)
`endif
    );

    pipe_elastic_reg #(
        .SIZE(32), .DEPTH(3)
`ifdef PIPE_STATS_EN
        , .STAT_W(4)
`endif
    ) u3 (
        .clk(clk), .reset(rst_n), .flush(flush), .bus(b3), .count(cnt3)
`ifdef PIPE_STATS_EN
        , .stall_cycles(st3)
`endif
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mq  [2][$];
    int          dep [2] = '{2, 3};
    int          mst [2] = '{0, 0};
    logic [31:0] got [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_head(input int k);
        return (mq[k].size() != 0) ? mq[k][0] : 32'd0;
    endfunction

    task automatic check_all();
        chk("u2_count",     32'(cnt2),         32'(mq[0].size()));
        chk("u2_out_valid", 32'(b2.out_valid), 32'(mq[0].size() != 0));
        chk("u2_in_ready",  32'(b2.in_ready),  32'(mq[0].size() < dep[0]));
        chk("u2_out_data",  b2.out_data,       exp_head(0));
        chk("u3_count",     32'(cnt3),         32'(mq[1].size()));
        chk("u3_out_valid", 32'(b3.out_valid), 32'(mq[1].size() != 0));
        chk("u3_in_ready",  32'(b3.in_ready),  32'(mq[1].size() < dep[1]));
        chk("u3_out_data",  b3.out_data,       exp_head(1));
`ifdef PIPE_STATS_EN
        chk("u2_stall", 32'(st2), 32'(mst[0]));
        chk("u3_stall", 32'(st3), 32'(mst[1]));
`endif
    endtask

    // Model advances at each rising edge from the driven inputs only.
    task automatic tick();
        bit full;
        bit do_pop;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                mq[k].delete();
                mst[k] = 0;
            end else begin
                full = (mq[k].size() >= dep[k]);
                if (drv_v && full && mst[k] < 15) mst[k]++;
                if (flush) begin
                    mq[k].delete();
                end else begin
                    do_pop = (mq[k].size() != 0) && drv_r;
                    if (do_pop) void'(mq[k].pop_front());
                    if (drv_v && !full) mq[k].push_back(drv_d);
                end
            end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
        drv_v = v;
        drv_d = d;
        drv_r = r;
        flush = f;
    endtask

    // Asserted between edges to exercise the asynchronous clear; released on a falling edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            mst[k] = 0;
        end
        check_all();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        bit acc;
        rst_n = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);

        // Reset values, then first push is visible after one edge
        do_reset();
        chk("rst_in_ready", 32'(b2.in_ready), 32'd1);
        chk("rst_out_data", b2.out_data, 32'd0);
        drive(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
        tick();
        chk("first_data", b2.out_data, 32'hA5A5_0001);
        chk("first_count", 32'(cnt2), 32'd1);

        // Fill and back-pressure
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'h11, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h22, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h33, 1'b0, 1'b0); tick();
        chk("full_count", 32'(cnt2), 32'd2);
        chk("full_in_ready", 32'(b2.in_ready), 32'd0);
        drv_r = 1'b1;
        got.delete();
        for (int i = 0; i < 8; i++) begin
            if (b2.out_valid) got.push_back(b2.out_data);
            acc = drv_v && b2.in_ready;
            tick();
            if (acc) drv_v = 1'b0;
        end
        chk("drain_len", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("drain_0", got[0], 32'h11);
            chk("drain_1", got[1], 32'h22);
            chk("drain_2", got[2], 32'h33);
        end

        // Streaming at full throughput
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 32'(i), 1'b1, 1'b0);
            tick();
            chk("stream_data", b2.out_data, 32'(i));
            chk("stream_count", 32'(cnt2), 32'd1);
        end

        // Flush discards held entries and the same-cycle push
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        repeat (4) tick();
        drive(1'b1, 32'h44, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h55, 1'b0, 1'b0); tick();
        chk("pre_flush_count", 32'(cnt2), 32'd2);
        drive(1'b1, 32'h66, 1'b0, 1'b1);
        tick();
        chk("flush_count", 32'(cnt2), 32'd0);
        chk("flush_out_valid", 32'(b2.out_valid), 32'd0);
        chk("flush_out_data", b2.out_data, 32'd0);
        chk("flush_in_ready", 32'(b2.in_ready), 32'd1);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        repeat (3) begin
            tick();
            chk("no_66", 32'(b2.out_valid), 32'd0);
        end

        // Random traffic with gaps and rare flushes; DEPTH=3 wraps its pointers
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 31) == 0));
            tick();
        end

        // Reset mid-transfer loses held data immediately
        drive(1'b1, 32'h77, 1'b0, 1'b0);
        tick();
        tick();
        drive(1'b1, 32'h78, 1'b1, 1'b0);
        do_reset();
        chk("async_rst_count", 32'(cnt3), 32'd0);
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        tick();

`ifdef PIPE_STATS_EN
        // Stall counter saturates, survives flush, clears on reset
        drive(1'b1, 32'h99, 1'b0, 1'b0);
        repeat (22) tick();
        chk("stall_sat_u2", 32'(st2), 32'd15);
        chk("stall_sat_u3", 32'(st3), 32'd15);
        drive(1'b1, 32'h9A, 1'b0, 1'b1);
        tick();
        chk("stall_after_flush", 32'(st2), 32'd15);
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        do_reset();
        chk("stall_after_reset", 32'(st2), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
